// File: rtl/full_adder_half_adder.sv
// half_adder: one-bit half adder used as the building block of the full adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/full_adder.sv
// full_adder: registered 1-bit full adder; chain selects the held carry for LSB-first bit-serial addition.
module full_adder (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic in_valid,
  input  logic chain,
  output logic s,
  output logic c,
  output logic out_valid
);
  logic cin, s1, c1, s2, c2;
  // The carry register c doubles as the held carry; it only moves on qualified cycles.
  assign cin = chain ? c : z;
  half_adder ha0 (.a(x), .b(y), .s(s1), .c(c1));
  half_adder ha1 (.a(s1), .b(cin), .s(s2), .c(c2));
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= 1'b0;
      c         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= s2;
        c <= c1 | c2;
      end
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed-vector self-checking bench for full_adder.
module tb_full_adder;
  logic clk = 1'b0;
  logic rst, x, y, z, in_valid, chain;
  logic s, c, out_valid;
  int checks = 0;
  int errors = 0;
  full_adder dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .in_valid(in_valid), .chain(chain),
    .s(s), .c(c), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic ch, input logic xi, input logic yi, input logic zi);
    rst = r; in_valid = v; chain = ch; x = xi; y = yi; z = zi;
    @(posedge clk);
    #1;
  endtask
  task automatic chk3(input string tag, input logic es, input logic ec, input logic ev);
    chk({tag, ".s"}, s, es);
    chk({tag, ".c"}, c, ec);
    chk({tag, ".ov"}, out_valid, ev);
  endtask
  initial begin
    logic [7:0] es, ec;
    logic [2:0] v;
    es = 8'b1001_0110;
    ec = 8'b1110_1000;
    rst = 1'b1; in_valid = 1'b0; chain = 1'b0; x = 1'b0; y = 1'b0; z = 1'b0;
    @(negedge clk);
    step(1, 1, 0, 1, 1, 1);
    chk3("reset0", 0, 0, 0);
    step(1, 1, 0, 1, 1, 1);
    chk3("reset1", 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      step(0, 1, 0, v[2], v[1], v[0]);
      chk3($sformatf("exh%0d", i), es[i], ec[i], 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, i[0], i[0], ~i[0], i[0]);
      chk3($sformatf("hold%0d", i), 1, 1, 0);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    chk3("ser0", 0, 1, 1);
    step(0, 1, 1, 1, 0, 0);
    chk3("ser1", 0, 1, 1);
    step(0, 1, 1, 0, 0, 0);
    chk3("ser2", 1, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    chk3("stl0", 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 1);
    chk3("stl_idle0", 0, 1, 0);
    step(0, 1, 1, 1, 0, 0);
    chk3("stl1", 0, 1, 1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    chk3("stl_idle1", 0, 1, 0);
    step(0, 1, 1, 0, 0, 0);
    chk3("stl2", 1, 0, 1);
    step(0, 1, 1, 1, 1, 1);
    chk3("zign", 0, 1, 1);
    step(0, 1, 0, 0, 0, 0);
    chk3("nochain", 0, 0, 1);
    step(0, 1, 1, 1, 1, 0);
    chk3("mid0", 0, 1, 1);
    step(1, 1, 1, 1, 1, 1);
    chk3("midrst", 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk3("mid1", 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have no parameters; all datapaths are 1 bit wide.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 x  input  1  addend bit A.
REQ-005 y  input  1  addend bit B.
REQ-006 z  input  1  carry-in bit, used when chain=0.
REQ-007 in_valid  input  1  qualifies x, y, z and chain for the current cycle.
REQ-008 chain  input  1  1 = carry-in taken from the internally held carry instead of z (bit-serial mode).
REQ-009 s  output  1  registered sum bit.
REQ-010 c  output  1  registered carry-out bit.
REQ-011 out_valid  output  1  s and c hold the result of a qualified input.
REQ-012 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.

Function
REQ-013 Effective carry-in SHALL be cin = chain ? c_hold : z, where c_hold is the carry register described in REQ-017.
REQ-014 The combinational result SHALL be sum = x XOR y XOR cin and cout = (x AND y) OR (cin AND (x XOR y)).
REQ-015 When in_valid=1 at a rising edge, s<=sum, c<=cout and out_valid<=1, giving 1-cycle latency.
REQ-016 When in_valid=0 at a rising edge, s and c SHALL hold their values and out_valid<=0.
REQ-017 c_hold SHALL equal register c, updating only on qualified cycles, so consecutive chained operations form an LSB-first bit-serial adder.
REQ-018 chain=1 on the first qualified cycle after reset SHALL use c_hold=0.
REQ-019 Gaps in in_valid SHALL NOT disturb c_hold, so a chained sequence may stall for any number of cycles.
REQ-020 chain=0 SHALL ignore c_hold completely and use z.
REQ-021 If rst=1 and in_valid=1 in the same cycle, reset SHALL take priority and the input SHALL be discarded.
REQ-022 Outputs SHALL be registered only, with no combinational path from inputs to s, c or out_valid.

Reset
REQ-023 On a rising edge with rst=1: s=0, c=0, c_hold=0, out_valid=0.
REQ-024 Reset asserted mid-sequence SHALL discard any chained carry; the next chained operation SHALL start with carry-in 0.
REQ-025 Behaviour is undefined only until the first clock edge with rst=1.

Structure
REQ-026 The sum/carry logic SHALL be built from two instances of a sub-module half_adder (inputs a, b; outputs s = a XOR b, c = a AND b), with cout = OR of the two half-adder carries.
REQ-027 A shared package is not needed; no typedefs or constants beyond 1-bit signals.
REQ-028 The top level SHALL contain only the cin mux, the two half_adder instances, and the s/c/out_valid registers.

Verification
REQ-029 Reset: rst=1 for 2 cycles with in_valid=1 and x=y=z=1 -> s=0, c=0, out_valid=0.
REQ-030 Exhaustive test, chain=0: apply xyz = 000, 001, 010, 011, 100, 101, 110, 111, one per cycle -> (s,c) one cycle later = 00, 10, 10, 01, 10, 01, 01, 11.
REQ-031 Hold: after x=y=z=1, drive in_valid=0 for 3 cycles while toggling the inputs -> s=1, c=1 held and out_valid=0.
REQ-032 Serial add, chain=1: add 3+1 LSB-first as (x,y) = (1,1), (1,0), (0,0) -> s sequence 0, 0, 1 (value 4) and c sequence 1, 1, 0.
REQ-033 Stall in chain: same as REQ-032 with 2 idle cycles between bits -> identical s/c sequence.
REQ-034 Reset mid-chain: after (x,y) = (1,1) with chain=1, pulse rst, then apply (0,0) with chain=1 -> s=0, c=0.
